// File: rtl/trace_buffer_unloader_if.sv
// Trace buffer unloader bus: buffer write monitor, read port, dump control and serial output.
// The slave modport is the unloader's view of the bus.
interface trace_buffer_unloader_if #(
  parameter int unsigned Fpay  = 32,
  parameter int unsigned TB_AW = 9
);
  logic             trigger_mon;
  logic             dump_req;
  logic             dump_stop;
  logic             tb_rd;
  logic [Fpay-1:0]  tb_dout;
  logic             shift_en;
  logic             tdo;
  logic             tdo_valid;
  logic             busy;
  logic             done;
  logic             ovf;
  logic [TB_AW:0]   occupancy;

  modport slave (
    input  trigger_mon, dump_req, dump_stop, tb_dout, shift_en,
    output tb_rd, tdo, tdo_valid, busy, done, ovf, occupancy
  );

  modport master (
    output trigger_mon, dump_req, dump_stop, tb_dout, shift_en,
    input  tb_rd, tdo, tdo_valid, busy, done, ovf, occupancy
  );
endinterface

// File: rtl/trace_buffer_unloader.sv
// Read-side engine for the NoC DfD trace buffer: tracks occupancy and drains words LSB-first onto tdo.
// Optional feature: define TB_UNLOAD_PARITY_EN to append an even-parity bit after every word.
module trace_buffer_unloader #(
  parameter int unsigned Fpay  = 32,
  parameter int unsigned TB_AW = 9
) (
  input  logic                    clk,
  input  logic                    reset,
  trace_buffer_unloader_if.slave  bus
);

`ifdef TB_UNLOAD_PARITY_EN
  localparam int unsigned NBITS = Fpay + 1;
`else
  localparam int unsigned NBITS = Fpay;
`endif
  localparam int unsigned CW = $clog2(NBITS);
  localparam int unsigned OW = TB_AW + 1;
  localparam logic [OW-1:0] CAP = {1'b1, {TB_AW{1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE, S_READ, S_WAIT, S_LOAD, S_SHIFT, S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic               tb_rd_q, tb_rd_d;
  logic               tdo_q, tdo_d;
  logic               tdo_valid_q, tdo_valid_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               stop_q, stop_d;
  logic [NBITS-1:0]   shreg_q, shreg_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [OW-1:0]      occ_q;
  logic               ovf_q;
  logic [NBITS-1:0]   load_word_c;

`ifdef TB_UNLOAD_PARITY_EN
  assign load_word_c = {^bus.tb_dout, bus.tb_dout};
`else
  assign load_word_c = bus.tb_dout;
`endif

  // Occupancy follows buffer writes and our own reads; a write while full loses the oldest word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      occ_q <= '0;
      ovf_q <= 1'b0;
    end else if (bus.trigger_mon && !tb_rd_q) begin
      if (occ_q == CAP) ovf_q <= 1'b1;
      else              occ_q <= occ_q + OW'(1);
    end else if (!bus.trigger_mon && tb_rd_q) begin
      occ_q <= occ_q - OW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      tb_rd_q     <= 1'b0;
      tdo_q       <= 1'b0;
      tdo_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      stop_q      <= 1'b0;
      shreg_q     <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      tb_rd_q     <= tb_rd_d;
      tdo_q       <= tdo_d;
      tdo_valid_q <= tdo_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      stop_q      <= stop_d;
      shreg_q     <= shreg_d;
      cnt_q       <= cnt_d;
    end
  end

  // tb_dout is valid during WAIT, so the word is captured on the WAIT->LOAD edge and
  // tdo_valid rises two cycles after tb_rd; LOAD itself consumes no shift_en.
  always_comb begin
    state_d     = state_q;
    tdo_d       = tdo_q;
    tdo_valid_d = tdo_valid_q;
    stop_d      = stop_q;
    shreg_d     = shreg_q;
    cnt_d       = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (bus.dump_req) state_d = (occ_q != '0) ? S_READ : S_DONE;
      end
      S_READ: state_d = S_WAIT;
      S_WAIT: begin
        state_d     = S_LOAD;
        shreg_d     = load_word_c;
        cnt_d       = '0;
        tdo_d       = load_word_c[0];
        tdo_valid_d = 1'b1;
      end
      S_LOAD: begin
        state_d = S_SHIFT;
        stop_d  = stop_q | bus.dump_stop;
      end
      S_SHIFT: begin
        stop_d = stop_q | bus.dump_stop;
        if (bus.shift_en) begin
          shreg_d = shreg_q >> 1;
          tdo_d   = shreg_q[1];
          cnt_d   = cnt_q + CW'(1);
          if (cnt_q == CW'(NBITS - 1)) begin
            tdo_d       = 1'b0;
            tdo_valid_d = 1'b0;
            state_d     = (stop_q || bus.dump_stop || occ_q == '0) ? S_DONE : S_READ;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        stop_d  = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
    tb_rd_d = (state_d == S_READ);
    busy_d  = (state_d != S_IDLE);
    done_d  = (state_d == S_DONE);
  end

  assign bus.tb_rd     = tb_rd_q;
  assign bus.tdo       = tdo_q;
  assign bus.tdo_valid = tdo_valid_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.ovf       = ovf_q;
  assign bus.occupancy = occ_q;

endmodule
